// File: rtl/gerenciador_de_posicionamento.sv
// Ship-placement manager for the 5x7 battleship board: validates each candidate ship
// against bounds and the committed map, and commits one ship per confirm press.
module gerenciador_de_posicionamento #(
  parameter int unsigned TAM0 = 3,
  parameter int unsigned TAM1 = 2,
  parameter int unsigned TAM2 = 2,
  parameter int unsigned TAM3 = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic       orientacao,
  input  logic       confirmar,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic [6:0] preview0,
  output logic [6:0] preview1,
  output logic [6:0] preview2,
  output logic [6:0] preview3,
  output logic [6:0] preview4,
  output logic [1:0] navioAtual,
  output logic       valido,
  output logic       erro,
  output logic       concluido
);

  typedef enum logic [1:0] {
    StOcioso,
    StPosicionando,
    StConcluido
  } estado_e;

  estado_e          estado_q;
  logic [4:0][6:0]  mapa_q;
  logic [1:0]       navio_q;
  logic             erro_q;
  logic             concluido_q;
  logic             conf_ant_q;

  logic [3:0]       tam;
  logic [3:0]       col4;
  logic [3:0]       lin4;
  logic [3:0]       fim4;
  logic             dentro;
  logic [4:0][6:0]  fp;
  logic [4:0][6:0]  prev;
  logic             pulso;

  assign pulso = confirmar & ~conf_ant_q;

  // Bounds are evaluated at 4 bits so anchor + length cannot wrap around the 3-bit grid.
  always_comb begin
    unique case (navio_q)
      2'd0:    tam = 4'(TAM0);
      2'd1:    tam = 4'(TAM1);
      2'd2:    tam = 4'(TAM2);
      default: tam = 4'(TAM3);
    endcase
    col4   = {1'b0, coordColuna};
    lin4   = {1'b0, coordLinha};
    fim4   = (orientacao ? lin4 : col4) + tam - 4'd1;
    dentro = (col4 <= 4'd4) && (lin4 <= 4'd6) &&
             (orientacao ? (fim4 <= 4'd6) : (fim4 <= 4'd4));
    fp     = '0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 7; r++) begin
        if (!orientacao) begin
          fp[c][r] = (4'(r) == lin4) && (4'(c) >= col4) && (4'(c) <= fim4);
        end else begin
          fp[c][r] = (4'(c) == col4) && (4'(r) >= lin4) && (4'(r) <= fim4);
        end
      end
    end
  end

  always_comb begin
    valido = (estado_q == StPosicionando) && dentro && ((fp & mapa_q) == '0);
    prev   = (estado_q == StPosicionando) ? (mapa_q | fp) : mapa_q;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      estado_q    <= StOcioso;
      mapa_q      <= '0;
      navio_q     <= 2'd0;
      erro_q      <= 1'b0;
      concluido_q <= 1'b0;
      // Held high so a button pressed across reset needs a release before it counts.
      conf_ant_q  <= 1'b1;
    end else begin
      conf_ant_q <= confirmar;
      unique case (estado_q)
        StOcioso: estado_q <= StPosicionando;
        StPosicionando: begin
          if (pulso) begin
            if (valido) begin
              mapa_q <= mapa_q | fp;
              erro_q <= 1'b0;
              if (navio_q == 2'd3) begin
                concluido_q <= 1'b1;
                estado_q    <= StConcluido;
              end else begin
                navio_q <= navio_q + 2'd1;
              end
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        default: estado_q <= StConcluido;
      endcase
    end
  end

  assign mapa0      = mapa_q[0];
  assign mapa1      = mapa_q[1];
  assign mapa2      = mapa_q[2];
  assign mapa3      = mapa_q[3];
  assign mapa4      = mapa_q[4];
  assign preview0   = prev[0];
  assign preview1   = prev[1];
  assign preview2   = prev[2];
  assign preview3   = prev[3];
  assign preview4   = prev[4];
  assign navioAtual = navio_q;
  assign erro       = erro_q;
  assign concluido  = concluido_q;

endmodule

// File: doc/gerenciador_de_posicionamento.md
# gerenciador_de_posicionamento

Ship-placement manager for the 5x7 LED battleship board. It takes the player's column/row/orientation selection and commits a fixed fleet, one ship per confirm, into the hidden map. It produces the `mapa0..mapa4` columns that the attack manager later reveals, plus a live preview for the LED matrix. It rejects placements that are out of bounds or overlapping, and signals completion when the whole fleet is down.

## Interface

Parameters:
- `TAM0`, default 3: length of ship 0, legal range 1..5.
- `TAM1`, default 2: length of ship 1, legal range 1..5.
- `TAM2`, default 2: length of ship 2, legal range 1..5.
- `TAM3`, default 1: length of ship 3, legal range 1..5.

Ports:
- `clock`  in  1: single clock; every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `enable`  in  1: high means placement mode is active. Low clears the block like `reset`.
- `coordColuna`  in  3: anchor column; legal values 0..4.
- `coordLinha`  in  3: anchor row; legal values 0..6.
- `orientacao`  in  1: 0 = horizontal, ship grows toward higher columns. 1 = vertical, ship grows toward higher rows.
- `confirmar`  in  1: level input from the button; the block edge-detects it internally.
- `mapa0`..`mapa4`  out  7 each: committed map. `mapaN` is column N; bit k is row k.
- `preview0`..`preview4`  out  7 each: committed map ORed with the current candidate footprint.
- `navioAtual`  out  2: index of the ship being placed (0..3).
- `valido`  out  1: combinational; the current candidate is legal.
- `erro`  out  1: registered; the last confirm was rejected.
- `concluido`  out  1: registered; all 4 ships are committed.

## Operation

- States:
  - OCIOSO (after reset, or whenever `enable`=0).
  - POSICIONANDO.
  - CONCLUIDO.
- Transitions:
  - OCIOSO goes to POSICIONANDO on the first clock with `enable`=1 and `reset`=0.
  - POSICIONANDO goes to CONCLUIDO when ship 3 commits.
  - CONCLUIDO is held until `reset` or `enable`=0.
- Confirm edge: `conf_ant` is a register holding the previous sample of `confirmar`.
  - `pulso` = `confirmar` & ~`conf_ant`.
  - `conf_ant` resets to 1, so a button held through reset or enable-low never produces a commit until it is released.
- Candidate footprint: anchor cell plus TAMi-1 further cells along the selected orientation, where i = `navioAtual`.
  - Only in-grid cells are shown in the preview. Out-of-grid cells are discarded, not wrapped.
- `valido` = 1 only if every one of the following holds:
  - state is POSICIONANDO;
  - `coordColuna` ≤ 4 and `coordLinha` ≤ 6;
  - horizontal: `coordColuna`+TAMi-1 ≤ 4; vertical: `coordLinha`+TAMi-1 ≤ 6;
  - no footprint cell is already set in `mapa`.
  - Bounds arithmetic is done at 4 bits so that 3-bit overflow cannot wrap.
- On `pulso` in POSICIONANDO:
  - If `valido`: OR the footprint into `mapa`, clear `erro`, and increment `navioAtual`. When committing ship 3, `navioAtual` stays at 3 and `concluido` is set.
  - If not `valido`: set `erro`. `mapa` and `navioAtual` are unchanged.
- `pulso` in OCIOSO or CONCLUIDO is ignored; `erro` is unchanged.
- `erro` stays set until the next valid commit, `reset`, or `enable`=0.
- Preview outputs:
  - `preview` = `mapa` | footprint in POSICIONANDO.
  - `preview` = `mapa` in the other states.
- Priority: `reset` > `enable`=0 > `pulso`.

## Timing

- Reset values, also applied on `enable`=0:
  - `mapa0..4` = 0, `preview0..4` = 0;
  - `navioAtual` = 0, `erro` = 0, `concluido` = 0, `valido` = 0;
  - state = OCIOSO, `conf_ant` = 1.
- First clock with `enable`=1 enters POSICIONANDO; `valido` and `preview` respond combinationally from the following cycle.
- Commit latency: `mapa`, `navioAtual`, `erro` and `concluido` update at the same rising edge at which `confirmar` is first sampled high. They are visible right after that edge.
- Holding `confirmar` high for N cycles yields exactly one commit or rejection.
- Coordinates and orientation may change every cycle. `valido` and `preview` follow with zero latency; only the edge that samples `pulso` matters.
- `reset` or `enable`=0 in any state, including the cycle with `pulso`, discards that commit and clears everything at that edge.

## Test plan

- Reset, then `enable`=1; ship 0 (size 3) horizontal at col 0, row 0, one confirm pulse:
  - `mapa0` = `mapa1` = `mapa2` = 0000001;
  - `navioAtual` = 1, `erro` = 0.
- Ship 1 (size 2) vertical at col 4, row 5, confirm:
  - `mapa4` = 1100000, `navioAtual` = 2.
  - Then ship 2 horizontal at col 4, row 0 (out of bounds), confirm: `erro` = 1, `valido` was 0, `mapa` unchanged, `navioAtual` = 2.
- Ship 2 vertical at col 1, row 0 (overlaps `mapa1` bit 0), confirm:
  - `erro` = 1, no change.
  - Then the same ship vertical at col 1, row 1, confirm: `mapa1` = 0000111, `erro` = 0, `navioAtual` = 3.
- Ship 3 (size 1) at col 3, row 3, confirm:
  - `mapa3` = 0001000, `concluido` = 1, `navioAtual` = 3.
  - A further pulse leaves everything unchanged.
- Hold `confirmar` high for 5 cycles with a valid candidate:
  - exactly one commit.
  - Hold `confirmar` high through `reset` release: no commit until it drops and rises again.
- With 2 ships placed, drive `enable`=0 for 1 cycle, coincident with a valid `pulso`:
  - all `mapa` = 0, `navioAtual` = 0, `erro` = 0, `concluido` = 0;
  - `preview` = 0 while `enable` is low.
